// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, fetch error codes and NOP word for imem_sync
package imem_pkg;
    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;
    typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_MIS = 2'b01, ERR_RANGE = 2'b10} ferr_t;
    localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x DATA_W storage, one write port and one synchronous read port
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/imem_sync.sv
// imem_sync: instruction memory loaded in LOAD state, fetched with one-cycle latency in RUN
module imem_sync
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH):0]   prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    input  logic                     prog_done,
    output logic                     prog_err,
    output logic [$clog2(DEPTH):0]   load_count,
    output logic                     run,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    input  logic                     stall,
    output logic                     fetch_valid,
    output logic [DATA_W-1:0]        fetch_instr,
    output logic [1:0]               fetch_err
);
    localparam int AW = $clog2(DEPTH);
    state_t            state;
    ferr_t             ferr;
    logic [DEPTH-1:0]  written;
    logic              zero_q;
    logic [DATA_W-1:0] rdata;
    logic              accept, mis, oor, wr_ok;
    logic [AW-1:0]     rd_idx, wr_idx;
    assign run         = state == RUN;
    assign accept      = run && !stall && fetch_req;
    assign mis         = fetch_addr[1:0] != 2'b00;
    assign oor         = (fetch_addr >> 2) >= ADDR_W'(DEPTH);
    assign rd_idx      = fetch_addr[AW+1:2];
    assign wr_idx      = prog_addr[AW-1:0];
    assign wr_ok       = !run && prog_we && !prog_addr[AW];
    assign fetch_err   = ferr;
    // Errors and never-written words read as NOP; array data itself is never reset
    assign fetch_instr = zero_q ? DATA_W'(NOP) : rdata;
    imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_idx),
        .wdata (prog_data),
        .re    (accept),
        .raddr (rd_idx),
        .rdata (rdata)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= LOAD;
            written     <= '0;
            load_count  <= '0;
            prog_err    <= 1'b0;
            fetch_valid <= 1'b0;
            ferr        <= ERR_OK;
            zero_q      <= 1'b1;
        end else begin
            prog_err <= !run && prog_we && prog_addr[AW];
            if (wr_ok) begin
                written[wr_idx] <= 1'b1;
                if (!written[wr_idx]) load_count <= load_count + 1'b1;
            end
            if (!run && prog_done) state <= RUN;
            if (!stall) begin
                fetch_valid <= accept;
                if (accept) begin
                    ferr   <= mis ? ERR_MIS : oor ? ERR_RANGE : ERR_OK;
                    zero_q <= mis || oor || !written[rd_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed and random stimulus checked against a behavioural model
module tb_imem_sync;
    localparam int DEPTH = 64;
    logic        clk = 1'b0;
    logic        rst_n, prog_we, prog_done, fetch_req, stall;
    logic [6:0]  prog_addr;
    logic [31:0] prog_data, fetch_addr;
    logic        prog_err, run, fetch_valid;
    logic [6:0]  load_count;
    logic [31:0] fetch_instr;
    logic [1:0]  fetch_err;
    int          checks = 0, errors = 0;
    logic [31:0] mem_m [DEPTH];
    bit          wr_m [DEPTH];
    int          cnt_m;
    bit          run_m, fv_m, perr_m;
    logic [31:0] fi_m;
    logic [1:0]  fe_m;

    always #5 clk = ~clk;

    imem_sync #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_done(prog_done), .prog_err(prog_err),
        .load_count(load_count), .run(run), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .stall(stall), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_err(fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (!rst_n) begin
            run_m = 0; cnt_m = 0; fv_m = 0; fi_m = 0; fe_m = 0; perr_m = 0;
            foreach (wr_m[i]) wr_m[i] = 0;
        end else begin
            perr_m = !run_m && prog_we && prog_addr >= DEPTH;
            if (run_m && !stall) begin
                fv_m = fetch_req;
                if (fetch_req) begin
                    if (fetch_addr % 4 != 0) begin fe_m = 2'b01; fi_m = 0; end
                    else if (fetch_addr / 4 >= DEPTH) begin fe_m = 2'b10; fi_m = 0; end
                    else begin fe_m = 2'b00; fi_m = wr_m[fetch_addr / 4] ? mem_m[fetch_addr / 4] : 0; end
                end
            end
            if (!run_m && prog_we && prog_addr < DEPTH) begin
                if (!wr_m[prog_addr]) cnt_m++;
                wr_m[prog_addr] = 1;
                mem_m[prog_addr] = prog_data;
            end
            if (!run_m && prog_done) run_m = 1;
        end
        @(posedge clk);
        #1;
        check("run", 32'(run), 32'(run_m));
        check("fetch_valid", 32'(fetch_valid), 32'(fv_m));
        check("fetch_instr", fetch_instr, fi_m);
        check("fetch_err", 32'(fetch_err), 32'(fe_m));
        check("prog_err", 32'(prog_err), 32'(perr_m));
        check("load_count", 32'(load_count), 32'(cnt_m));
    endtask

    task automatic idle();
        prog_we = 0; prog_done = 0; fetch_req = 0; stall = 0;
    endtask

    task automatic load(input int a, input logic [31:0] d, input bit done);
        prog_we = 1; prog_addr = a[6:0]; prog_data = d; prog_done = done;
        tick();
        prog_we = 0; prog_done = 0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req = 1; fetch_addr = a;
        tick();
        fetch_req = 0;
    endtask

    task automatic reset();
        rst_n = 0; tick(); tick(); rst_n = 1;
    endtask

    initial begin
        logic [31:0] prog [4] = '{32'h20080020, 32'h20090037, 32'h01098024, 32'h01098025};
        idle(); prog_addr = 0; prog_data = 0; fetch_addr = 0;
        reset();
        check("rst_load_count", 32'(load_count), 0);
        for (int i = 0; i < 4; i++) load(i, prog[i], 0);
        prog_done = 1; tick(); prog_done = 0;
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4));
            check("b2b_instr", fetch_instr, prog[i]);
            check("b2b_valid", 32'(fetch_valid), 1);
        end
        check("count4", 32'(load_count), 4);
        fetch(32'h6);   check("mis_err", 32'(fetch_err), 1);
        fetch(32'h100); check("oor_err", 32'(fetch_err), 2); check("oor_instr", fetch_instr, 0);
        fetch(32'h102); check("mis_pri", 32'(fetch_err), 1);
        fetch(32'h0);
        stall = 1; fetch_req = 1; fetch_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin tick(); check("stall_hold", fetch_instr, prog[0]); end
        stall = 0; tick(); check("after_stall", fetch_instr, prog[1]);
        idle(); tick();
        reset();
        load(0, 32'hAAAA0000, 0);
        load(64, 32'hDEAD0000, 0);
        check("prog_err", 32'(prog_err), 1);
        tick(); check("prog_err_off", 32'(prog_err), 0);
        load(0, 32'h12345678, 0);
        check("rewrite_cnt", 32'(load_count), 1);
        load(5, 32'h00000555, 1);
        check("run_now", 32'(run), 1);
        fetch(32'h14); check("word5", fetch_instr, 32'h555);
        fetch(32'h18); check("unwritten", fetch_instr, 0); check("unwritten_err", 32'(fetch_err), 0);
        fetch(32'h0);  check("rewritten", fetch_instr, 32'h12345678);
        load(7, 32'h77, 0);
        fetch_req = 1; fetch_addr = 0; rst_n = 0; tick(); rst_n = 1; fetch_req = 0;
        check("mid_rst_run", 32'(run), 0); check("mid_rst_valid", 32'(fetch_valid), 0);
        fetch(32'h0); check("load_no_fetch", 32'(fetch_valid), 0);
        prog_done = 1; tick(); prog_done = 0;
        fetch(32'h0); check("stale_nop", fetch_instr, 0);
        reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n     = $urandom_range(0, 199) != 0;
            prog_we   = $urandom_range(0, 1) == 1;
            prog_addr = 7'($urandom_range(0, 80));
            prog_data = $urandom;
            prog_done = $urandom_range(0, 29) == 0;
            fetch_req = $urandom_range(0, 3) != 0;
            stall     = $urandom_range(0, 3) == 0;
            fetch_addr = ($urandom_range(0, 7) == 0) ? $urandom
                       : (32'($urandom_range(0, 70)) << 2) | 32'($urandom_range(0, 5) == 0 ? $urandom_range(1, 3) : 0);
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_sync.md
IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning number of words; power of two, 2..4096.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte-address width of the fetch port.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning synchronous, active-low reset, sampled on rising clk.
REQ-006 SHALL have port prog_we  input  1  meaning load-port write strobe.
REQ-007 SHALL have port prog_addr  input  $clog2(DEPTH)+1  meaning word index for the load write.
REQ-008 SHALL have port prog_data  input  DATA_W  meaning instruction word to load.
REQ-009 SHALL have port prog_done  input  1  meaning end-of-load pulse.
REQ-010 SHALL have port prog_err  output  1  meaning one-cycle pulse on a rejected load write.
REQ-011 SHALL have port load_count  output  $clog2(DEPTH)+1  meaning number of distinct words written since reset.
REQ-012 SHALL have port run  output  1  meaning block is in RUN state and accepts fetches.
REQ-013 SHALL have port fetch_req  input  1  meaning fetch request.
REQ-014 SHALL have port fetch_addr  input  ADDR_W  meaning byte address (PC).
REQ-015 SHALL have port stall  input  1  meaning hold fetch outputs and ignore fetch_req.
REQ-016 SHALL have port fetch_valid  output  1  meaning fetch_instr/fetch_err are valid this cycle.
REQ-017 SHALL have port fetch_instr  output  DATA_W  meaning fetched instruction.
REQ-018 SHALL have port fetch_err  output  2  meaning 00 ok, 01 misaligned, 10 out of range.

Function
REQ-019 SHALL implement two states: LOAD (after reset) and RUN; LOAD->RUN on prog_done=1; no other transitions except reset to LOAD.
REQ-020 SHALL in LOAD write prog_data to word prog_addr on prog_we=1 when prog_addr<DEPTH, and set that word's written bit.
REQ-021 SHALL on prog_we=1 with prog_addr>=DEPTH discard the write and pulse prog_err for exactly the next cycle.
REQ-022 SHALL increment load_count only when a word is written whose written bit was clear; rewrites update data, not the count.
REQ-023 SHALL, when prog_we and prog_done coincide in LOAD, perform the write, then enter RUN.
REQ-024 SHALL in RUN ignore prog_we (no write, no prog_err) and ignore further prog_done.
REQ-025 SHALL in LOAD ignore fetch_req and hold fetch_valid=0.
REQ-026 SHALL in RUN, with stall=0 and fetch_req=1, register a result one cycle later: fetch_valid=1, fetch_err and fetch_instr per REQ-027..029.
REQ-027 SHALL flag fetch_err=01, fetch_instr=0 when fetch_addr[1:0]!=0; misaligned takes priority over out-of-range.
REQ-028 SHALL flag fetch_err=10, fetch_instr=0 when fetch_addr>>2 >= DEPTH.
REQ-029 SHALL otherwise return the stored word with fetch_err=00, or 0 (MIPS nop) if the word's written bit is clear.
REQ-030 SHALL, with stall=0 and fetch_req=0 in RUN, drive fetch_valid=0 next cycle and hold fetch_instr/fetch_err.
REQ-031 SHALL, with stall=1, hold fetch_valid, fetch_instr and fetch_err unchanged and discard fetch_req.
REQ-032 SHALL support back-to-back fetches at one per cycle with fixed latency 1.

Reset
REQ-033 SHALL on rst_n=0 at a clock edge enter LOAD and set run=0, fetch_valid=0, fetch_instr=0, fetch_err=00, prog_err=0, load_count=0, all written bits 0.
REQ-034 SHALL not clear storage array contents on reset; cleared written bits make stale data unreadable.
REQ-035 SHALL give reset priority over every concurrent input, including mid-load writes and in-flight fetches.

Structure
REQ-036 SHALL place state encoding, fetch_err codes and the NOP constant in shared package imem_pkg.
REQ-037 SHALL instantiate one sub-module imem_array (1 write port, 1 synchronous read port, DEPTH x DATA_W) holding the storage; written bits and control stay in imem_sync.

Verification
REQ-038 SHALL cover: load words 0..3 with 0x20080020,0x20090037,0x01098024,0x01098025, prog_done, fetch 0x0,0x4,0x8,0xC back-to-back -> those words on 4 consecutive cycles, err 00, load_count=4.
REQ-039 SHALL cover: in RUN fetch 0x6 -> err 01, instr 0; fetch 0x100 with DEPTH=64 -> err 10, instr 0; fetch 0x102 -> err 01.
REQ-040 SHALL cover: load prog_addr=64 (DEPTH=64) -> prog_err one cycle, load_count unchanged; rewrite word 0 -> count unchanged, new data fetched.
REQ-041 SHALL cover: fetch 0x0 then stall=1 for 3 cycles with fetch_req=1, addr 0x4 -> outputs hold word 0 for all 3 cycles; stall=0 -> word 1 next cycle.
REQ-042 SHALL cover: prog_we+prog_done same cycle at word 5 -> run=1 next cycle, fetch 0x14 returns word; fetch of unwritten word 6 -> 0, err 00.
REQ-043 SHALL cover: rst_n=0 mid-RUN -> run=0, load_count=0, fetch_valid=0; fetch 0x0 in LOAD -> no fetch_valid; after prog_done fetch 0x0 -> 0.
